pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch-address controller that drives the 8-bit program_counter input of mips_core, replacing hand-stepped PC values with a clocked sequencer.
- Holds each PC for a programmable dwell, advances sequentially, redirects on branch/jump, honours stall and halt, and signals completion at a programmed last address.
- Sits between the top-level control (start/halt) and mips_core; branch/jump inputs come from core decode.

Parameters:
- RESET_PC, 8'd0, address loaded on reset and on restart from DONE.
- LAST_PC, 8'd14, final address of the program; a sequential advance from it ends the run.
- DWELL, 1, clock cycles each PC is held before advancing (1..255).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse: begin, resume or restart execution.
- halt_req  input  1  stop fetching and hold the current PC.
- stall  input  1  freeze the PC and the dwell counter this cycle.
- branch_taken  input  1  conditional branch resolved taken for the current PC.
- branch_offset  input  8  signed word offset relative to PC+1.
- jump_valid  input  1  unconditional jump for the current PC.
- jump_target  input  8  absolute jump address.
- program_counter  output  8  address presented to mips_core.
- pc_valid  output  1  program_counter is a live fetch address.
- done  output  1  high while in DONE.
- retired_count  output  16  number of PC advances since the last (re)start.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, program_counter=RESET_PC, pc_valid=0, done=0, dwell_cnt=0, retired_count=0.
- States: IDLE, RUN, HALTED, DONE. All transitions occur on the rising edge of clock.
- IDLE:
  - On start: go to RUN, program_counter=RESET_PC, dwell_cnt=0, retired_count=0.
  - pc_valid rises in the same edge that enters RUN.
- RUN:
  - pc_valid=1.
  - dwell_cnt increments each cycle while stall=0; it holds while stall=1.
  - An advance cycle is a cycle where dwell_cnt==DWELL-1 and stall=0.
  - On an advance cycle, the next PC is chosen in priority order:
    - jump_valid: jump_target.
    - else branch_taken: PC+1+branch_offset, computed in 8-bit two's complement, wrapping mod 256.
    - else: PC+1, wrapping 255 to 0.
  - On an advance, dwell_cnt resets to 0 and retired_count increments, saturating at 16'hFFFF.
  - branch_taken, jump_valid, branch_offset and jump_target are ignored on non-advance cycles.
  - A sequential advance with PC==LAST_PC goes to DONE. PC holds LAST_PC and retired_count still increments.
  - A jump or branch taken at LAST_PC redirects normally and does not end the run.
- halt_req in RUN:
  - Go to HALTED on the next edge; PC and dwell_cnt are held; pc_valid=0.
  - halt_req has priority over an advance in the same cycle: no advance, no count.
- HALTED:
  - start resumes RUN at the held PC with dwell_cnt cleared; retired_count is kept.
  - halt_req while in HALTED has no effect.
- DONE:
  - done=1, pc_valid=0, PC held.
  - start restarts as from IDLE: PC=RESET_PC, retired_count=0.
- start in RUN is ignored.
- start and halt_req asserted together in IDLE, HALTED or DONE: start wins. halt_req is then evaluated from RUN on the next cycle.
- stall and halt_req together: halt wins.
- stall has no effect outside RUN.
- Asserting reset_n=0 mid-run clears everything immediately, with no clock required. There is no pending state after reset is released.
- Output timing:
  - All outputs are registered; no combinational path from inputs to outputs.
  - Redirect latency is one edge: the new PC appears after the advance edge.

Test Plan:
- Reset, DWELL=1, pulse start, no redirects -> PC steps 0,1,...,14, one value per cycle. done=1 after 15 advances, retired_count=15, pc_valid falls with done.
- DWELL=3, start, stall held 2 cycles during PC=4 -> PC=4 visible for 5 cycles, then PC=5; total cycles to DONE = 15*3+2.
- At PC=6 advance cycle: branch_taken=1, branch_offset=8'hFC (-4) -> next PC=3. At PC=3, jump_valid=1, jump_target=8'd12 with branch_taken=1 also asserted -> PC=12 (jump priority).
- Wrap: RESET_PC=8'd254, LAST_PC=8'd1 -> PC 254,255,0,1 then DONE. Branch at PC=250 with offset 8'd10 -> PC=5.
- halt_req at PC=7 on an advance cycle -> HALTED, PC stays 7, pc_valid=0, retired_count=7. start -> RUN resumes at 7, then 8.
- Assert reset_n=0 mid-run at PC=9, asynchronously between edges -> PC=0, pc_valid=0, state IDLE immediately. start after release -> run restarts from PC=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: clocked fetch-address controller for mips_core.
// Dwell, sequential advance, branch/jump redirect, stall, halt, done.
module pc_sequencer #(
  parameter logic [7:0]  RESET_PC = 8'd0,
  parameter logic [7:0]  LAST_PC  = 8'd14,
  parameter int unsigned DWELL    = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_offset,
  input  logic        jump_valid,
  input  logic [7:0]  jump_target,
  output logic [7:0]  program_counter,
  output logic        pc_valid,
  output logic        done,
  output logic [15:0] retired_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED,
    S_DONE
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [15:0] ret_q, ret_d;
  logic [7:0]  seq_pc;
  logic [7:0]  br_pc;

  assign seq_pc = pc_q + 8'd1;
  assign br_pc  = seq_pc + branch_offset;

  // State, PC, dwell and retire registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      dwell_q <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dwell_q <= dwell_d;
      ret_q   <= ret_d;
    end
  end

  // Next state: start/resume, halt, dwell count and PC selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dwell_d = dwell_q;
    ret_d   = ret_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
          dwell_d = '0;
          ret_d   = '0;
        end
      end
      S_HALTED: begin
        if (start) begin
          state_d = S_RUN;
          dwell_d = '0;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALTED;
        end else if (!stall) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (ret_q != 16'hFFFF) begin
              ret_d = ret_q + 16'd1;
            end
            if (jump_valid) begin
              pc_d = jump_target;
            end else if (branch_taken) begin
              pc_d = br_pc;
            end else if (pc_q == LAST_PC) begin
              state_d = S_DONE;
            end else begin
              pc_d = seq_pc;
            end
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign program_counter = pc_q;
  assign pc_valid        = (state_q == S_RUN);
  assign done            = (state_q == S_DONE);
  assign retired_count   = ret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: three pc_sequencer configs on shared stimulus,
// each compared every cycle against a behavioural model.
module tb_pc_sequencer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       halt_req = 1'b0;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_offset = 8'd0;
  logic       jump_valid = 1'b0;
  logic [7:0] jump_target = 8'd0;

  logic [7:0]  pc_o [3];
  logic        val_o [3];
  logic        done_o [3];
  logic [15:0] ret_o [3];

  int cfg_rst [3] = '{0, 0, 254};
  int cfg_last [3] = '{14, 14, 1};
  int cfg_dw [3] = '{1, 3, 1};

  int m_pc [3];
  int m_age [3];
  int m_ret [3];
  bit m_run [3];
  bit m_halt [3];
  bit m_done [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  pc_sequencer u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .halt_req(halt_req), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .program_counter(pc_o[0]), .pc_valid(val_o[0]),
    .done(done_o[0]), .retired_count(ret_o[0])
  );

  pc_sequencer #(.DWELL(3)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .halt_req(halt_req), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .program_counter(pc_o[1]), .pc_valid(val_o[1]),
    .done(done_o[1]), .retired_count(ret_o[1])
  );

  pc_sequencer #(.RESET_PC(8'd254), .LAST_PC(8'd1)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .halt_req(halt_req), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .program_counter(pc_o[2]), .pc_valid(val_o[2]),
    .done(done_o[2]), .retired_count(ret_o[2])
  );

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pc[i] = cfg_rst[i];
      m_age[i] = 0;
      m_ret[i] = 0;
      m_run[i] = 0;
      m_halt[i] = 0;
      m_done[i] = 0;
    end
  endtask

  task automatic model_tick();
    for (int i = 0; i < 3; i++) begin
      if (m_run[i]) begin
        if (halt_req) begin
          m_run[i] = 0;
          m_halt[i] = 1;
        end else if (!stall) begin
          m_age[i]++;
          if (m_age[i] == cfg_dw[i]) begin
            m_age[i] = 0;
            if (m_ret[i] < 65535) m_ret[i]++;
            if (jump_valid)
              m_pc[i] = jump_target;
            else if (branch_taken)
              m_pc[i] = (m_pc[i] + 1 +
                         int'($signed(branch_offset))) & 255;
            else if (m_pc[i] == cfg_last[i]) begin
              m_run[i] = 0;
              m_done[i] = 1;
            end else
              m_pc[i] = (m_pc[i] + 1) % 256;
          end
        end
      end else if (start) begin
        m_run[i] = 1;
        m_age[i] = 0;
        if (m_halt[i]) begin
          m_halt[i] = 0;
        end else begin
          m_pc[i] = cfg_rst[i];
          m_ret[i] = 0;
          m_done[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pc%0d", i), pc_o[i], m_pc[i]);
      check($sformatf("valid%0d", i), val_o[i], m_run[i]);
      check($sformatf("done%0d", i), done_o[i], m_done[i]);
      check($sformatf("ret%0d", i), ret_o[i], m_ret[i]);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_tick();
    #1;
    compare_all();
  endtask

  task automatic wait_pc0(int v);
    int n = 0;
    while (pc_o[0] != 8'(v) && n < 300) begin
      step();
      n++;
    end
    check("wait_pc0", pc_o[0], v);
  endtask

  initial begin
    int n;
    int stalls_left;
    model_reset();
    #12;
    compare_all();
    @(negedge clock);
    reset_n = 1'b1;

    // plain runs on all configs, with a 2-cycle stall at PC=4 on dut1
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    stalls_left = 2;
    while (!done_o[1] && n < 200) begin
      if (pc_o[1] == 8'd4 && stalls_left > 0) begin
        stall = 1'b1;
        stalls_left--;
      end else begin
        stall = 1'b0;
      end
      step();
      n++;
    end
    stall = 1'b0;
    check("dwell3_cycles", n, 47);
    check("run0_done", done_o[0], 1);
    check("run0_ret", ret_o[0], 15);
    check("run0_pc", pc_o[0], 14);
    check("run0_valid", val_o[0], 0);
    check("run1_ret", ret_o[1], 15);
    check("wrap_done", done_o[2], 1);
    check("wrap_ret", ret_o[2], 4);
    check("wrap_pc", pc_o[2], 1);

    // branch back then jump with branch also asserted
    start = 1'b1;
    step();
    start = 1'b0;
    wait_pc0(6);
    branch_taken = 1'b1;
    branch_offset = 8'hFC;
    step();
    branch_taken = 1'b0;
    check("branch_back", pc_o[0], 3);
    jump_valid = 1'b1;
    jump_target = 8'd12;
    branch_taken = 1'b1;
    step();
    jump_valid = 1'b0;
    branch_taken = 1'b0;
    check("jump_prio", pc_o[0], 12);
    n = 0;
    while (!done_o[0] && n < 100) begin
      step();
      n++;
    end
    check("done0_wait", done_o[0], 1);

    // halt at PC=7 on an advance cycle, then resume
    start = 1'b1;
    step();
    start = 1'b0;
    wait_pc0(7);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_pc", pc_o[0], 7);
    check("halt_valid", val_o[0], 0);
    check("halt_ret", ret_o[0], 7);
    start = 1'b1;
    step();
    start = 1'b0;
    check("resume_pc", pc_o[0], 7);
    check("resume_valid", val_o[0], 1);
    step();
    check("resume_next", pc_o[0], 8);

    // asynchronous reset between edges
    wait_pc0(9);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_pc", pc_o[0], 0);
    check("async_valid", val_o[0], 0);
    #2;
    reset_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_pc", pc_o[0], 0);
    check("restart_valid", val_o[0], 1);

    // wrapping branch on the wrap config
    jump_valid = 1'b1;
    jump_target = 8'd250;
    step();
    jump_valid = 1'b0;
    check("wrap_jump", pc_o[2], 250);
    branch_taken = 1'b1;
    branch_offset = 8'd10;
    step();
    branch_taken = 1'b0;
    branch_offset = 8'd0;
    check("wrap_branch", pc_o[2], 5);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom % 20) == 0;
      halt_req = ($urandom % 25) == 0;
      stall = ($urandom % 6) == 0;
      branch_taken = ($urandom % 5) == 0;
      branch_offset = 8'($urandom);
      jump_valid = ($urandom % 8) == 0;
      jump_target = 8'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
